alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl_if.sv | 51 +++++
 rtl/alarm_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// ---------------------------------------------------------------------------
// alarm_ctrl_if
// Purpose : groups the keypad/sensor inputs and the status outputs of the
//           alarm controller into one bundle.
// Signals : arm, disarm        - one-cycle keypad request pulses
//           zone_in, zone_en   - smoothed zone sensors and monitor mask (NZ)
//           tamper             - enclosure tamper switch (ALARM_CTRL_TAMPER_EN)
//           state              - current state code (3 bits)
//           armed, siren, buzzer, filt_clr, arm_fail - status/pulse outputs
//           trig_zone          - latched mask of zones that caused the alarm
// Modports: master drives requests/sensors, slave is the controller.
// Macro   : ALARM_CTRL_TAMPER_EN adds the tamper signal.
// ---------------------------------------------------------------------------
interface alarm_ctrl_if #(
    parameter int NZ = 4
) ();
    logic          arm;
    logic          disarm;
    logic [NZ-1:0] zone_in;
    logic [NZ-1:0] zone_en;
`ifdef ALARM_CTRL_TAMPER_EN
    logic          tamper;
`endif
    logic [2:0]    state;
    logic          armed;
    logic          siren;
    logic          buzzer;
    logic          filt_clr;
    logic          arm_fail;
    logic [NZ-1:0] trig_zone;

`ifdef ALARM_CTRL_TAMPER_EN
    modport master (
        output arm, disarm, zone_in, zone_en, tamper,
        input  state, armed, siren, buzzer, filt_clr, arm_fail, trig_zone
    );
    modport slave (
        input  arm, disarm, zone_in, zone_en, tamper,
        output state, armed, siren, buzzer, filt_clr, arm_fail, trig_zone
    );
`else
    modport master (
        output arm, disarm, zone_in, zone_en,
        input  state, armed, siren, buzzer, filt_clr, arm_fail, trig_zone
    );
    modport slave (
        input  arm, disarm, zone_in, zone_en,
        output state, armed, siren, buzzer, filt_clr, arm_fail, trig_zone
    );
`endif
endinterface

// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
// Purpose : intrusion alarm controller. Zone 0 is the delayed entry/exit
//           zone, zones 1..NZ-1 trigger the alarm instantly. Sequence is
//           DISARMED -> EXIT_DELAY -> ARMED -> (ENTRY_DELAY) -> ALARM, with
//           auto re-arm once the siren period expires.
// Ports   : CLK    - system clock, all state changes on its rising edge
//           RST_N  - asynchronous active-low reset
//           bus    - alarm_ctrl_if.slave (requests, sensors, status outputs)
// Params  : NZ (zones), EXIT_CYC, ENTRY_CYC, SIREN_CYC (cycle counts)
// Macro   : ALARM_CTRL_TAMPER_EN - when defined, tamper forces ALARM from
//           any other state. Default build has no tamper logic.
// All outputs are registered and respond one edge after their inputs.
// ---------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int NZ        = 4,
    parameter int EXIT_CYC  = 16,
    parameter int ENTRY_CYC = 16,
    parameter int SIREN_CYC = 64
) (
    input logic         CLK,
    input logic         RST_N,
    alarm_ctrl_if.slave bus
);
    localparam int MAX_AB = (EXIT_CYC > ENTRY_CYC) ? EXIT_CYC : ENTRY_CYC;
    localparam int MAX_C  = (MAX_AB > SIREN_CYC) ? MAX_AB : SIREN_CYC;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_CYC - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_CYC - 1);
    localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NZ-1:0] trig_q, trig_d;
    logic          armed_q, armed_d;
    logic          siren_q, siren_d;
    logic          buzzer_q, buzzer_d;
    logic          filt_clr_q, filt_clr_d;
    logic          arm_fail_q, arm_fail_d;

    logic [NZ-1:0] act;
    logic          inst;
    logic          dly;

    assign act  = bus.zone_in & bus.zone_en;
    assign inst = |act[NZ-1:1];
    assign dly  = act[0];

    // Next-state logic. Disarm always wins over every other request; the
    // shared counter is reloaded on each delay/alarm entry so it never wraps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trig_d     = trig_q;
        filt_clr_d = 1'b0;
        arm_fail_d = 1'b0;
        case (state_q)
            S_DISARMED: begin
                if (!bus.disarm && bus.arm) begin
                    if (act == '0) begin
                        state_d    = S_EXIT;
                        cnt_d      = EXIT_LD;
                        trig_d     = '0;
                        filt_clr_d = 1'b1;
                    end else begin
                        arm_fail_d = 1'b1;
                    end
                end
            end
            S_EXIT: begin
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ARMED: begin
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (inst) begin
                    state_d = S_ALARM;
                    cnt_d   = SIREN_LD;
                    trig_d  = trig_q | act;
                end else if (dly) begin
                    state_d = S_ENTRY;
                    cnt_d   = ENTRY_LD;
                end
            end
            S_ENTRY: begin
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (inst || cnt_q == '0) begin
                    state_d = S_ALARM;
                    cnt_d   = SIREN_LD;
                    trig_d  = trig_q | act;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ALARM: begin
                // Zones keep accumulating during the siren without
                // restarting its timer.
                trig_d = trig_q | act;
                if (bus.disarm) begin
                    state_d = S_DISARMED;
                end else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_DISARMED;
            end
        endcase
`ifdef ALARM_CTRL_TAMPER_EN
        // Tamper overrides everything outside ALARM; inside ALARM a disarm
        // still leaves, and a persisting tamper pulls it back next cycle.
        if (bus.tamper && state_q != S_ALARM) begin
            state_d    = S_ALARM;
            cnt_d      = SIREN_LD;
            trig_d     = trig_q;
            filt_clr_d = 1'b0;
            arm_fail_d = 1'b0;
        end
`endif
    end

    // Status outputs are decoded from the next state so that they are
    // registered alongside it and change on the same edge.
    always_comb begin
        armed_d  = (state_d == S_ARMED) || (state_d == S_ENTRY) ||
                   (state_d == S_ALARM);
        siren_d  = (state_d == S_ALARM);
        buzzer_d = (state_d == S_EXIT) || (state_d == S_ENTRY);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_DISARMED;
            cnt_q      <= '0;
            trig_q     <= '0;
            armed_q    <= 1'b0;
            siren_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            filt_clr_q <= 1'b0;
            arm_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trig_q     <= trig_d;
            armed_q    <= armed_d;
            siren_q    <= siren_d;
            buzzer_q   <= buzzer_d;
            filt_clr_q <= filt_clr_d;
            arm_fail_q <= arm_fail_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.armed     = armed_q;
    assign bus.siren     = siren_q;
    assign bus.buzzer    = buzzer_q;
    assign bus.filt_clr  = filt_clr_q;
    assign bus.arm_fail  = arm_fail_q;
    assign bus.trig_zone = trig_q;
endmodule

// File: tb/tb_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl
// Directed bench for alarm_ctrl with default parameters (NZ=4, EXIT=16,
// ENTRY=16, SIREN=64). Inputs change 1 ns after a rising edge and outputs
// are checked at the same point, so every check sees the result of the
// previous edge.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl;
    logic CLK;
    logic RST_N;
    int   nAsserts;
    int   nFails;

    alarm_ctrl_if #(.NZ(4)) bus ();

    alarm_ctrl #(
        .NZ(4), .EXIT_CYC(16), .ENTRY_CYC(16), .SIREN_CYC(64)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    // 100 MHz free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic armV, input logic disarmV,
                                 input logic [3:0] zin, input logic [3:0] zen);
        bus.arm     = armV;
        bus.disarm  = disarmV;
        bus.zone_in = zin;
        bus.zone_en = zen;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full set of status outputs in one go.
    task automatic checkAll(input string tag, input logic [2:0] st,
                            input logic ar, input logic si, input logic bz,
                            input logic fc, input logic af,
                            input logic [3:0] tz);
        checkOutput({tag, ".state"},     32'(bus.state),     32'(st));
        checkOutput({tag, ".armed"},     32'(bus.armed),     32'(ar));
        checkOutput({tag, ".siren"},     32'(bus.siren),     32'(si));
        checkOutput({tag, ".buzzer"},    32'(bus.buzzer),    32'(bz));
        checkOutput({tag, ".filt_clr"},  32'(bus.filt_clr),  32'(fc));
        checkOutput({tag, ".arm_fail"},  32'(bus.arm_fail),  32'(af));
        checkOutput({tag, ".trig_zone"}, 32'(bus.trig_zone), 32'(tz));
    endtask

    // Arm from DISARMED with clear zones and walk through the exit delay.
    task automatic armAndWait(input string tag);
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll({tag, ".exit1"}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        repeat (15) tick();
        checkAll({tag, ".exit16"}, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        checkAll({tag, ".armed"}, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        RST_N    = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
`ifdef ALARM_CTRL_TAMPER_EN
        bus.tamper = 1'b0;
`endif
        #2;
        checkAll("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        checkAll("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Arm with zone 1 open: rejected, one-cycle arm_fail.
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0010, 4'b1111);
        checkAll("armFail", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        tick();
        checkOutput("armFailPulse", 32'(bus.arm_fail), 32'd0);

        // Arm and disarm together act as disarm.
        applyStimulus(1'b1, 1'b1, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll("armDisarm", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Disarm during exit delay.
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll("exitAbort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        armAndWait("arm1");

        // Delayed zone: 16 cycles of entry delay, then alarm.
        applyStimulus(1'b0, 1'b0, 4'b0001, 4'b1111);
        tick();
        checkAll("entry1", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        repeat (15) tick();
        checkOutput("entry16.state", 32'(bus.state), 32'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll("alarm1", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001);
        repeat (63) tick();
        checkOutput("alarm64.state", 32'(bus.state), 32'd4);
        tick();
        checkAll("rearm", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);

        // Disarm from ARMED; trig_zone is cleared only by the next arm.
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll("disarmed", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        armAndWait("arm2");

        // Instant zone 2 masked off: no reaction.
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'b1011);
        repeat (3) tick();
        checkAll("masked", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        // Enable it: alarm on the very next edge.
        applyStimulus(1'b0, 1'b0, 4'b0100, 4'b1111);
        tick();
        checkAll("instant", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);

        // More zones during the alarm accumulate into trig_zone.
        applyStimulus(1'b0, 1'b0, 4'b1000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkAll("accum", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100);

        // Asynchronous reset at alarm cycle 10, asserted between edges.
        repeat (8) tick();
        checkOutput("alarm10.state", 32'(bus.state), 32'd4);
        #2;
        RST_N = 1'b0;
        #1;
        checkAll("asyncRst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        RST_N = 1'b1;
        tick();
        checkAll("postRst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

`ifdef ALARM_CTRL_TAMPER_EN
        // Tamper from DISARMED forces alarm on the next edge.
        bus.tamper = 1'b1;
        tick();
        checkAll("tamper", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        // Disarm leaves ALARM, persisting tamper re-enters it.
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b1111);
        checkOutput("tamperDisarm.state", 32'(bus.state), 32'd0);
        tick();
        checkOutput("tamperReenter.state", 32'(bus.state), 32'd4);
        bus.tamper = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end
endmodule
